// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with valid/ready handshake.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   in_valid / in_ready           upstream handshake
//   in_nop                        accepted entry is stored with ctrl forced to zero
//   in_ctrl, in_tag, in_data      entry payload
//   flush                         drop every held entry and the entry offered this cycle
//   out_valid / out_ready         downstream handshake
//   out_ctrl, out_tag, out_data   presented payload (ctrl is zero when out_valid=0)
//   occupancy                     registered count of held entries (0..2)
//
// Build option
//   ID_EX_STAGE_SKID_EN  defined: main + skid slot, in_ready is registered
//                                 (no combinational path from out_ready).
//                        undefined: single slot, in_ready = !out_valid || out_ready.
module id_ex_stage #(
  parameter int unsigned WORD_BITWIDTH = 32,
  parameter int unsigned CTRL_BITWIDTH = 10,
  parameter int unsigned TAG_BITWIDTH  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_nop,
  input  logic [CTRL_BITWIDTH-1:0] in_ctrl,
  input  logic [TAG_BITWIDTH-1:0]  in_tag,
  input  logic [WORD_BITWIDTH-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_BITWIDTH-1:0] out_ctrl,
  output logic [TAG_BITWIDTH-1:0]  out_tag,
  output logic [WORD_BITWIDTH-1:0] out_data,
  output logic [1:0]               occupancy
);

  logic                     in_xfer;
  logic                     out_xfer;
  logic [CTRL_BITWIDTH-1:0] in_ctrl_eff;

  logic                     main_valid_q, main_valid_d;
  logic [CTRL_BITWIDTH-1:0] main_ctrl_q,  main_ctrl_d;
  logic [TAG_BITWIDTH-1:0]  main_tag_q,   main_tag_d;
  logic [WORD_BITWIDTH-1:0] main_data_q,  main_data_d;
  logic [1:0]               occupancy_q,  occupancy_d;

`ifdef ID_EX_STAGE_SKID_EN
  logic                     skid_valid_q, skid_valid_d;
  logic [CTRL_BITWIDTH-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [TAG_BITWIDTH-1:0]  skid_tag_q,   skid_tag_d;
  logic [WORD_BITWIDTH-1:0] skid_data_q,  skid_data_d;
  logic                     in_ready_q,   in_ready_d;

  assign in_ready = in_ready_q;
`else
  assign in_ready = !main_valid_q || out_ready;
`endif

  always_comb begin
    in_ctrl_eff  = in_nop ? '0 : in_ctrl;
    out_xfer     = main_valid_q && out_ready;
    in_xfer      = in_valid && in_ready && !flush;

    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_tag_d   = main_tag_q;
    main_data_d  = main_data_q;
`ifdef ID_EX_STAGE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_tag_d   = skid_tag_q;
    skid_data_d  = skid_data_q;
`endif

    if (flush) begin
      // tag/data keep their last value; only valid and ctrl are cleared
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
`ifdef ID_EX_STAGE_SKID_EN
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
`endif
    end else if (!main_valid_q || out_xfer) begin
      // main slot is free this edge: refill from skid first to keep order
`ifdef ID_EX_STAGE_SKID_EN
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_tag_d   = skid_tag_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else
`endif
      if (in_xfer) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl_eff;
        main_tag_d   = in_tag;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end
`ifdef ID_EX_STAGE_SKID_EN
    else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl_eff;
      skid_tag_d   = in_tag;
      skid_data_d  = in_data;
    end
    in_ready_d  = !skid_valid_d;
    occupancy_d = 2'(main_valid_d) + 2'(skid_valid_d);
`else
    occupancy_d = 2'(main_valid_d);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_tag_q   <= '0;
      main_data_q  <= '0;
      occupancy_q  <= '0;
`ifdef ID_EX_STAGE_SKID_EN
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_tag_q   <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_tag_q   <= main_tag_d;
      main_data_q  <= main_data_d;
      occupancy_q  <= occupancy_d;
`ifdef ID_EX_STAGE_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_tag_q   <= skid_tag_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_tag   = main_tag_q;
  assign out_data  = main_data_q;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomised checks of id_ex_stage for whichever buffering
// build (ID_EX_STAGE_SKID_EN defined or not) the bench is compiled with.
module tb_id_ex_stage;

`ifdef ID_EX_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_nop = 1'b0;
  logic [9:0]  in_ctrl = '0;
  logic [14:0] in_tag = '0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_ctrl;
  logic [14:0] out_tag;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int checks = 0;
  int fails  = 0;

  id_ex_stage #(
    .WORD_BITWIDTH(32),
    .CTRL_BITWIDTH(10),
    .TAG_BITWIDTH (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_nop   (in_nop),
    .in_ctrl  (in_ctrl),
    .in_tag   (in_tag),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_tag  (out_tag),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // inputs change 1 time unit after the rising edge; checks happen 1 unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_nop = 1'b0;
    in_ctrl = '0; in_tag = '0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_ctrl, out_tag, out_data, occupancy, in_ready} !== {1'b0, 10'h0, 15'h0, 32'h0, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset: got v=%b c=%h t=%h d=%h occ=%0d rdy=%b, want all zero, rdy=1",
               out_valid, out_ctrl, out_tag, out_data, occupancy, in_ready);
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    in_valid = 1'b1; in_ctrl = 10'h3FF; in_tag = 15'h0007; in_data = 32'h0000_0011; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_ctrl, out_tag, out_data, occupancy} !== {1'b1, 10'h3FF, 15'h0007, 32'h11, 2'd1}) begin
      fails++;
      $display("FAIL basic_cyc1: got v=%b c=%h t=%h d=%h occ=%0d, want v=1 c=3ff t=0007 d=11 occ=1",
               out_valid, out_ctrl, out_tag, out_data, occupancy);
    end
    step();
    #1;
    checks++;
    if ({out_valid, out_ctrl, out_data, occupancy} !== {1'b0, 10'h0, 32'h11, 2'd0}) begin
      fails++;
      $display("FAIL basic_cyc2: got v=%b c=%h d=%h occ=%0d, want v=0 c=0 d=11(held) occ=0",
               out_valid, out_ctrl, out_data, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    int     rdy_tab[7]  = '{1, 1, 0, 0, 1, 1, 1};
`ifdef ID_EX_STAGE_SKID_EN
    int     irdy_tab[7] = '{1, 1, 1, 0, 0, 1, 1};
    int     occ_tab[7]  = '{0, 1, 1, 2, 2, 1, 1};
`else
    int     irdy_tab[7] = '{1, 1, 0, 0, 1, 1, 1};
    int     occ_tab[7]  = '{0, 1, 1, 1, 1, 1, 1};
`endif
    int     dat_tab[7]  = '{0, 1, 2, 2, 2, 3, 4};
    int     idx = 1;
    int     got[$];
    idle_inputs();
    for (int c = 0; c < 7; c++) begin
      in_valid  = (idx <= 4);
      in_data   = 32'(idx);
      in_tag    = 15'(idx);
      in_ctrl   = 10'h001;
      out_ready = (rdy_tab[c] != 0);
      #1;
      checks++;
      if ({in_ready, occupancy, out_valid} !== {irdy_tab[c] != 0, 2'(occ_tab[c]), c != 0}) begin
        fails++;
        $display("FAIL stream_ctl c%0d: got rdy=%b occ=%0d v=%b, want rdy=%0d occ=%0d v=%0d",
                 c, in_ready, occupancy, out_valid, irdy_tab[c], occ_tab[c], c != 0);
      end
      if (c != 0) begin
        checks++;
        if (out_data !== 32'(dat_tab[c])) begin
          fails++;
          $display("FAIL stream_data c%0d: got %h, want %h", c, out_data, dat_tab[c]);
        end
      end
      if (out_valid && out_ready) got.push_back(int'(out_data));
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (got.size() != 4 || got[0] != 1 || got[1] != 2 || got[2] != 3 || got[3] != 4 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_order: got %0d items %p v=%b, want 1,2,3,4 then v=0", got.size(), got, out_valid);
    end
  endtask

  task automatic test_nop();
    idle_inputs();
    in_valid = 1'b1; in_nop = 1'b1; in_ctrl = 10'h155; in_tag = 15'h1234; in_data = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    #1;
    checks++;
    if ({out_valid, out_ctrl, out_tag, out_data, occupancy} !== {1'b1, 10'h0, 15'h1234, 32'hDEAD_BEEF, 2'd1}) begin
      fails++;
      $display("FAIL nop: got v=%b c=%h t=%h d=%h occ=%0d, want v=1 c=0 t=1234 d=deadbeef occ=1",
               out_valid, out_ctrl, out_tag, out_data, occupancy);
    end
    step();
    #1;
    checks++;
    if ({out_valid, occupancy} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL nop_hold: got v=%b occ=%0d, want bubble held v=1 occ=1", out_valid, occupancy);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      fails++;
      $display("FAIL nop_drain: got v=%b occ=%0d, want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1'b1; in_ctrl = 10'h00A; in_tag = 15'h000A; in_data = 32'hA;
    step();
    in_ctrl = 10'h00B; in_tag = 15'h000B; in_data = 32'hB;
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'(CAP)) begin
      fails++;
      $display("FAIL flush_fill: got occ=%0d, want %0d", occupancy, CAP);
    end
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 10'h00C; in_tag = 15'h000C; in_data = 32'hC; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_ctrl, occupancy, out_data} !== {1'b0, 10'h0, 2'd0, 32'hA}) begin
      fails++;
      $display("FAIL flush: got v=%b c=%h occ=%0d d=%h, want v=0 c=0 occ=0 d=a(held)",
               out_valid, out_ctrl, occupancy, out_data);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
        fails++;
        $display("FAIL flush_ghost c%0d: got v=%b occ=%0d d=%h, want v=0 occ=0", c, out_valid, occupancy, out_data);
      end
    end
  endtask

  task automatic test_reset_stall();
    idle_inputs();
    in_valid = 1'b1; in_ctrl = 10'h2AA; in_tag = 15'h0055; in_data = 32'h1234_5678;
    step();
    step();
    in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_ctrl, out_tag, out_data, occupancy, in_ready} !== {1'b0, 10'h0, 15'h0, 32'h0, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_stall: got v=%b c=%h t=%h d=%h occ=%0d rdy=%b, want zeros rdy=1",
               out_valid, out_ctrl, out_tag, out_data, occupancy, in_ready);
    end
  endtask

  typedef struct packed {
    logic [9:0]  c;
    logic [14:0] t;
    logic [31:0] d;
  } ent_t;

  task automatic test_random();
    ent_t        q[$];
    logic [14:0] last_t = '0;
    logic [31:0] last_d = '0;
    logic        exp_rdy;
    logic [9:0]  exp_c;
    logic [14:0] exp_t;
    logic [31:0] exp_d;
    int          rand_fails = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    for (int n = 0; n < 10000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_nop    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = 10'($urandom);
      in_tag    = 15'($urandom);
      in_data   = $urandom;
      #1;
      exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready);
      exp_c   = (q.size() > 0) ? q[0].c : 10'h0;
      exp_t   = (q.size() > 0) ? q[0].t : last_t;
      exp_d   = (q.size() > 0) ? q[0].d : last_d;
      checks++;
      if ({out_valid, out_ctrl, out_tag, out_data, occupancy, in_ready} !==
          {q.size() > 0, exp_c, exp_t, exp_d, 2'(q.size()), exp_rdy}) begin
        fails++;
        if (rand_fails < 10)
          $display("FAIL random n%0d: got v=%b c=%h t=%h d=%h occ=%0d rdy=%b, want v=%b c=%h t=%h d=%h occ=%0d rdy=%b",
                   n, out_valid, out_ctrl, out_tag, out_data, occupancy, in_ready,
                   q.size() > 0, exp_c, exp_t, exp_d, q.size(), exp_rdy);
        rand_fails++;
      end
      if (rst) begin
        q.delete();
        last_t = '0;
        last_d = '0;
      end else if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back('{c: in_nop ? 10'h0 : in_ctrl, t: in_tag, d: in_data});
      end
      if (q.size() > 0) begin
        last_t = q[0].t;
        last_d = q[0].d;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_back_to_back();
    test_nop();
    test_flush();
    test_reset_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
